// File: rtl/branch_history_table.sv
// Dual-slot branch-direction predictor: saturating counters, bimodal or gshare indexing.
// Optional same-cycle update forwarding onto the lookup path when BHT_BYPASS_EN is defined.
module branch_history_table #(
    parameter int ENTRIES   = 64,
    parameter int CTR_BITS  = 2,
    parameter int HIST_BITS = 0,
    localparam int IDX_W    = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      lookup_pc,
    output logic             pred_taken0,
    output logic             pred_taken1,
    output logic [IDX_W-1:0] pred_idx0,
    output logic [IDX_W-1:0] pred_idx1,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int NUM_SLOTS = 2;
    localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((2 ** (CTR_BITS - 1)) - 1);
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
        logic             taken;
    } upd_req_t;

    upd_req_t                             upd;
    logic [CTR_BITS-1:0]                  ctr [ENTRIES];
    logic [IDX_W-1:0]                     hist;
    logic [IDX_W-2:0]                     pair_base;
    logic [NUM_SLOTS-1:0][IDX_W-1:0]      idx;
    logic [NUM_SLOTS-1:0]                 pred;
    logic                                 unused_pc;

    assign upd       = {upd_valid, upd_idx, upd_taken};
    assign pair_base = lookup_pc[IDX_W+1:3];
    assign unused_pc = ^{lookup_pc[31:IDX_W+2], lookup_pc[2:0]};

    function automatic logic [CTR_BITS-1:0] sat_next(input logic [CTR_BITS-1:0] c,
                                                     input logic taken);
        if (taken)
            return (c == CTR_MAX) ? c : c + CTR_BITS'(1);
        return (c == '0) ? c : c - CTR_BITS'(1);
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++)
                ctr[i] <= CTR_INIT;
        end else if (upd.valid) begin
            ctr[upd.idx] <= sat_next(ctr[upd.idx], upd.taken);
        end
    end

    // History is trained only at resolution, so it is never speculative.
    generate
        if (HIST_BITS == 0) begin : g_bimodal
            assign hist = '0;
        end else begin : g_gshare
            logic [HIST_BITS-1:0] ghr;
            if (HIST_BITS == 1) begin : g_h1
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)            ghr <= '0;
                    else if (upd.valid) ghr <= upd.taken;
                end
            end else begin : g_hn
                always_ff @(posedge clk or posedge rst) begin
                    if (rst)            ghr <= '0;
                    else if (upd.valid) ghr <= {ghr[HIST_BITS-2:0], upd.taken};
                end
            end
            assign hist = IDX_W'(ghr);
        end
    endgenerate

    generate
        for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
            logic [CTR_BITS-1:0] rd;
            assign idx[s] = {pair_base, 1'(s)} ^ hist;
`ifdef BHT_BYPASS_EN
            assign rd = (upd.valid && upd.idx == idx[s]) ? sat_next(ctr[idx[s]], upd.taken)
                                                          : ctr[idx[s]];
`else
            assign rd = ctr[idx[s]];
`endif
            assign pred[s] = rd[CTR_BITS-1];
        end
    endgenerate

    assign pred_idx0   = idx[0];
    assign pred_idx1   = idx[1];
    assign pred_taken0 = pred[0];
    assign pred_taken1 = pred[1];

endmodule

// File: tb/tb_branch_history_table.sv
// Randomised and directed bench for branch_history_table: a bimodal and a gshare(4) instance
// share all inputs and are compared against an integer-array reference model.
module tb_branch_history_table;

    logic       clk = 0;
    logic       rst = 0;
    logic [31:0] lookup_pc = 0;
    logic       upd_valid = 0;
    logic [5:0] upd_idx = 0;
    logic       upd_taken = 0;

    logic       bm_p0, bm_p1, gs_p0, gs_p1;
    logic [5:0] bm_i0, bm_i1, gs_i0, gs_i1;

    int checks = 0;
    int errors = 0;

    // Reference state: plain counter values 0..3 and history as an integer 0..15.
    int bm_cnt [64];
    int gs_cnt [64];
    int ghr;

    branch_history_table #(.ENTRIES(64), .CTR_BITS(2), .HIST_BITS(0)) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_taken0(bm_p0), .pred_taken1(bm_p1), .pred_idx0(bm_i0), .pred_idx1(bm_i1),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken));

    branch_history_table #(.ENTRIES(64), .CTR_BITS(2), .HIST_BITS(4)) dut_gs (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_taken0(gs_p0), .pred_taken1(gs_p1), .pred_idx0(gs_i0), .pred_idx1(gs_i1),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic int next_cnt(int c, bit t);
        if (t) return (c < 3) ? c + 1 : 3;
        return (c > 0) ? c - 1 : 0;
    endfunction

    function automatic int slot_idx(logic [31:0] pc, int slot, int h);
        return ((((pc >> 3) * 2) + slot) % 64) ^ h;
    endfunction

    // Prediction seen this cycle, including forwarding of a same-cycle update when enabled.
    function automatic bit exp_pred(int c, int idx);
        int v = c;
`ifdef BHT_BYPASS_EN
        if (upd_valid && int'(upd_idx) == idx) v = next_cnt(c, upd_taken);
`endif
        return v >= 2;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 64; i++) begin bm_cnt[i] = 1; gs_cnt[i] = 1; end
        ghr = 0;
    endfunction

    function automatic void model_update(int idx, bit t);
        bm_cnt[idx] = next_cnt(bm_cnt[idx], t);
        gs_cnt[idx] = next_cnt(gs_cnt[idx], t);
        ghr = ((ghr * 2) + int'(t)) % 16;
    endfunction

    task automatic apply_reset();
        rst = 1; upd_valid = 0;
        #3; rst = 0;
        model_reset();
        @(posedge clk); #1;
    endtask

    task automatic do_update(int idx, bit t);
        upd_valid = 1; upd_idx = 6'(idx); upd_taken = t;
        @(posedge clk); #1;
        upd_valid = 0;
        model_update(idx, t);
    endtask

    task automatic test_reset();
        rst = 1; lookup_pc = 32'h0000_0040; upd_valid = 0;
        #1;
        checks++; if (bm_p0 !== 1'b0 || bm_p1 !== 1'b0) begin errors++;
            $display("FAIL reset_pred got %b%b want 00", bm_p0, bm_p1); end
        checks++; if (bm_i0 !== 6'd16 || bm_i1 !== 6'd17) begin errors++;
            $display("FAIL reset_idx got %0d/%0d want 16/17", bm_i0, bm_i1); end
        checks++; if (gs_i0 !== 6'd16 || gs_i1 !== 6'd17 || gs_p0 !== 1'b0) begin errors++;
            $display("FAIL reset_gs got idx %0d/%0d p %b want 16/17 0", gs_i0, gs_i1, gs_p0); end
        @(posedge clk); #1;
        rst = 0;
        model_reset();
    endtask

    task automatic test_saturation();
        apply_reset();
        lookup_pc = 32'h14;
        for (int i = 0; i < 3; i++) do_update(5, 1);
        #1;
        checks++; if (bm_i1 !== 6'd5 || bm_p1 !== 1'b1) begin errors++;
            $display("FAIL sat_up got idx %0d p %b want 5 1", bm_i1, bm_p1); end
        do_update(5, 0);
        checks++; if (bm_p1 !== 1'b1) begin errors++;
            $display("FAIL sat_dec1 got %b want 1", bm_p1); end
        do_update(5, 0);
        checks++; if (bm_p1 !== 1'b0) begin errors++;
            $display("FAIL sat_dec2 got %b want 0", bm_p1); end
        for (int i = 0; i < 6; i++) do_update(5, 0);
        // From 00, two taken steps are needed to predict taken; a wrap would break this.
        do_update(5, 1);
        checks++; if (bm_p1 !== 1'b0) begin errors++;
            $display("FAIL sat_floor1 got %b want 0", bm_p1); end
        do_update(5, 1);
        checks++; if (bm_p1 !== 1'b1) begin errors++;
            $display("FAIL sat_floor2 got %b want 1", bm_p1); end
        for (int i = 0; i < 6; i++) do_update(5, 1);
        do_update(5, 0);
        checks++; if (bm_p1 !== 1'b1) begin errors++;
            $display("FAIL sat_ceiling got %b want 1", bm_p1); end
    endtask

    task automatic test_aliasing();
        apply_reset();
        do_update(0, 1);
        do_update(0, 1);
        lookup_pc = 32'h100;
        #1;
        checks++; if (bm_i0 !== 6'd0 || bm_p0 !== 1'b1) begin errors++;
            $display("FAIL alias got idx %0d p %b want 0 1", bm_i0, bm_p0); end
    endtask

    task automatic test_gshare();
        apply_reset();
        do_update(40, 1); do_update(41, 1); do_update(42, 0); do_update(43, 1);
        lookup_pc = 32'h0;
        #1;
        checks++; if (gs_i0 !== 6'd13 || gs_i1 !== 6'd12) begin errors++;
            $display("FAIL gshare_idx got %0d/%0d want 13/12", gs_i0, gs_i1); end
        checks++; if (bm_i0 !== 6'd0 || bm_i1 !== 6'd1) begin errors++;
            $display("FAIL bimodal_idx got %0d/%0d want 0/1", bm_i0, bm_i1); end
    endtask

    task automatic test_bypass();
        bit want_now;
        apply_reset();
`ifdef BHT_BYPASS_EN
        want_now = 1'b1;
`else
        want_now = 1'b0;
`endif
        lookup_pc = 32'hC;
        upd_valid = 1; upd_idx = 6'd3; upd_taken = 1;
        #1;
        checks++; if (bm_i1 !== 6'd3 || bm_p1 !== want_now) begin errors++;
            $display("FAIL bypass_same got idx %0d p %b want 3 %b", bm_i1, bm_p1, want_now); end
        @(posedge clk); #1;
        upd_valid = 0;
        model_update(3, 1);
        checks++; if (bm_p1 !== 1'b1) begin errors++;
            $display("FAIL bypass_next got %b want 1", bm_p1); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        do_update(7, 1); do_update(7, 1);
        lookup_pc = 32'h1C;
        #1;
        checks++; if (bm_i1 !== 6'd7 || bm_p1 !== 1'b1) begin errors++;
            $display("FAIL areset_pre got idx %0d p %b want 7 1", bm_i1, bm_p1); end
        #1; rst = 1;
        #1;
        checks++; if (bm_p1 !== 1'b0) begin errors++;
            $display("FAIL areset_now got %b want 0", bm_p1); end
        upd_valid = 1; upd_idx = 6'd7; upd_taken = 1;
        @(posedge clk); #1;
        checks++; if (bm_p1 !== 1'b0) begin errors++;
            $display("FAIL areset_drop got %b want 0", bm_p1); end
        rst = 0;
        model_reset();
        @(posedge clk); #1;
        upd_valid = 0;
        model_update(7, 1);
        checks++; if (bm_p1 !== 1'b1) begin errors++;
            $display("FAIL areset_first_upd got %b want 1", bm_p1); end
    endtask

    task automatic test_random();
        int e_bi0, e_bi1, e_gi0, e_gi1;
        bit e_bp0, e_bp1, e_gp0, e_gp1;
        apply_reset();
        for (int n = 0; n < 400; n++) begin
            lookup_pc = $urandom();
            upd_valid = ($urandom_range(0, 3) != 0);
            upd_idx   = 6'($urandom_range(0, 63));
            upd_taken = ($urandom_range(0, 2) != 0);
            #1;
            e_bi0 = slot_idx(lookup_pc, 0, 0);
            e_bi1 = slot_idx(lookup_pc, 1, 0);
            e_gi0 = slot_idx(lookup_pc, 0, ghr);
            e_gi1 = slot_idx(lookup_pc, 1, ghr);
            e_bp0 = exp_pred(bm_cnt[e_bi0], e_bi0);
            e_bp1 = exp_pred(bm_cnt[e_bi1], e_bi1);
            e_gp0 = exp_pred(gs_cnt[e_gi0], e_gi0);
            e_gp1 = exp_pred(gs_cnt[e_gi1], e_gi1);
            checks++;
            if (int'(bm_i0) != e_bi0 || int'(bm_i1) != e_bi1 || bm_p0 !== e_bp0 || bm_p1 !== e_bp1) begin
                errors++;
                $display("FAIL rand_bimodal n=%0d got %0d/%0d %b%b want %0d/%0d %b%b",
                         n, bm_i0, bm_i1, bm_p0, bm_p1, e_bi0, e_bi1, e_bp0, e_bp1);
            end
            checks++;
            if (int'(gs_i0) != e_gi0 || int'(gs_i1) != e_gi1 || gs_p0 !== e_gp0 || gs_p1 !== e_gp1) begin
                errors++;
                $display("FAIL rand_gshare n=%0d got %0d/%0d %b%b want %0d/%0d %b%b",
                         n, gs_i0, gs_i1, gs_p0, gs_p1, e_gi0, e_gi1, e_gp0, e_gp1);
            end
            @(posedge clk); #1;
            if (upd_valid) model_update(int'(upd_idx), upd_taken);
        end
        upd_valid = 0;
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_saturation();
        test_aliasing();
        test_gshare();
        test_bypass();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
